// File: rtl/onehot_data_mux_pkg.sv
// Shared definitions for one-hot select consumers: default word width and
// multi-hot detection over a select vector of up to MAX_SEL_W bits.
package onehot_data_mux_pkg;

  localparam int unsigned DEFAULT_W_INPUT = 32;
  localparam int unsigned MAX_SEL_W       = 256;

  // Two or more bits set exactly when clearing the lowest set bit leaves a residue.
  function automatic logic is_multi_hot(input logic [MAX_SEL_W-1:0] vec);
    logic [MAX_SEL_W-1:0] low_cleared;
    low_cleared = vec & (vec - MAX_SEL_W'(1));
    return (low_cleared != '0);
  endfunction

endpackage

// File: rtl/onehot_sel_check.sv
// Select-vector integrity flags: more-than-one-hot and all-zero, both combinational.
module onehot_sel_check
  import onehot_data_mux_pkg::*;
#(
  parameter int unsigned N_INPUTS = 2
) (
  input  logic [N_INPUTS-1:0] sel,
  output logic                sel_multi,
  output logic                sel_none
);

  assign sel_multi = is_multi_hot(MAX_SEL_W'(sel));
  assign sel_none  = (sel == '0);

endmodule

// File: rtl/onehot_data_mux.sv
// AND-OR read-data mux with one-hot select and sticky multi-hot error flag.
// Define ONEHOT_DATA_MUX_OUT_REG_EN to register out (one cycle latency).
module onehot_data_mux
  import onehot_data_mux_pkg::*;
#(
  parameter int unsigned N_INPUTS = 2,
  parameter int unsigned W_INPUT  = DEFAULT_W_INPUT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_INPUTS*W_INPUT-1:0]   in,
  input  logic [N_INPUTS-1:0]           sel,
  output logic [W_INPUT-1:0]            out,
  output logic                          sel_multi,
  output logic                          sel_none,
  input  logic                          err_clr,
  output logic                          err_sticky
);

  if (N_INPUTS == 0 || N_INPUTS > MAX_SEL_W || W_INPUT == 0) begin : g_bad_param
    $error("onehot_data_mux: unsupported N_INPUTS/W_INPUT");
  end

  logic [W_INPUT-1:0] masked [N_INPUTS];
  logic [W_INPUT-1:0] mux_c;

  // Each word is gated by its own select bit; no priority between words.
  for (genvar i = 0; i < N_INPUTS; i++) begin : g_word
    assign masked[i] = in[i*W_INPUT +: W_INPUT] & {W_INPUT{sel[i]}};
  end

  always_comb begin
    mux_c = '0;
    for (int unsigned i = 0; i < N_INPUTS; i++) begin
      mux_c = mux_c | masked[i];
    end
  end

  onehot_sel_check #(
    .N_INPUTS (N_INPUTS)
  ) u_sel_check (
    .sel       (sel),
    .sel_multi (sel_multi),
    .sel_none  (sel_none)
  );

`ifdef ONEHOT_DATA_MUX_OUT_REG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else begin
      out <= mux_c;
    end
  end
`else
  assign out = mux_c;
`endif

  // A new multi-hot select takes priority over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
    end else if (sel_multi) begin
      err_sticky <= 1'b1;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_onehot_data_mux.sv
// Self-checking bench for onehot_data_mux: N=2/W=32 and N=4/W=8 instances,
// directed steps followed by random traffic against a behavioural model.
module tb_onehot_data_mux;

  localparam int unsigned N2 = 2;
  localparam int unsigned W2 = 32;
  localparam int unsigned N4 = 4;
  localparam int unsigned W4 = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N2*W2-1:0]  in2;
  logic [N2-1:0]     sel2;
  logic              clr2;
  logic [W2-1:0]     out2;
  logic              multi2, none2, sticky2;
  logic [N4*W4-1:0]  in4;
  logic [N4-1:0]     sel4;
  logic              clr4;
  logic [W4-1:0]     out4;
  logic              multi4, none4, sticky4;

  int checks = 0;
  int failures = 0;

  logic        exp_sticky2, exp_sticky4;
  logic [31:0] exp_q2, exp_q4;

  always #5 clk = ~clk;

  onehot_data_mux #(.N_INPUTS(N2), .W_INPUT(W2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in(in2), .sel(sel2), .out(out2),
    .sel_multi(multi2), .sel_none(none2), .err_clr(clr2), .err_sticky(sticky2)
  );

  onehot_data_mux #(.N_INPUTS(N4), .W_INPUT(W4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in(in4), .sel(sel4), .out(out4),
    .sel_multi(multi4), .sel_none(none4), .err_clr(clr4), .err_sticky(sticky4)
  );

  function automatic logic [31:0] ref2(input logic [N2*W2-1:0] d, input logic [N2-1:0] s);
    logic [31:0] r = '0;
    for (int i = 0; i < int'(N2); i++) if (s[i]) r = r | 32'(d[i*W2 +: W2]);
    return r;
  endfunction

  function automatic logic [31:0] ref4(input logic [N4*W4-1:0] d, input logic [N4-1:0] s);
    logic [31:0] r = '0;
    for (int i = 0; i < int'(N4); i++) if (s[i]) r = r | 32'(d[i*W4 +: W4]);
    return r;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
`ifdef ONEHOT_DATA_MUX_OUT_REG_EN
    cmp({tag, ".out2"}, 32'(out2), exp_q2);
    cmp({tag, ".out4"}, 32'(out4), exp_q4);
`else
    cmp({tag, ".out2"}, 32'(out2), ref2(in2, sel2));
    cmp({tag, ".out4"}, 32'(out4), ref4(in4, sel4));
`endif
    cmp({tag, ".multi2"}, 32'(multi2), 32'($countones(sel2) >= 2));
    cmp({tag, ".none2"},  32'(none2),  32'(sel2 == '0));
    cmp({tag, ".sticky2"}, 32'(sticky2), 32'(exp_sticky2));
    cmp({tag, ".multi4"}, 32'(multi4), 32'($countones(sel4) >= 2));
    cmp({tag, ".none4"},  32'(none4),  32'(sel4 == '0));
    cmp({tag, ".sticky4"}, 32'(sticky4), 32'(exp_sticky4));
  endtask

  // Check mid-cycle, then advance the model across one rising edge.
  task automatic step(input string tag);
    @(negedge clk);
    check_all(tag);
    @(posedge clk);
    if (rst_n) begin
      if ($countones(sel2) >= 2) exp_sticky2 = 1'b1;
      else if (clr2)             exp_sticky2 = 1'b0;
      if ($countones(sel4) >= 2) exp_sticky4 = 1'b1;
      else if (clr4)             exp_sticky4 = 1'b0;
      exp_q2 = ref2(in2, sel2);
      exp_q4 = ref4(in4, sel4);
    end
    #1;
  endtask

  initial begin
    logic [W2-1:0] w0, w1;
    rst_n = 1'b0;
    exp_sticky2 = 1'b0; exp_sticky4 = 1'b0;
    exp_q2 = '0; exp_q4 = '0;
    w1 = 32'hDEADBEEF; w0 = 32'h12345678;
    in2 = {w1, w0};
    sel2 = 2'b01; clr2 = 1'b0;
    in4 = {8'h08, 8'h04, 8'h02, 8'h01};
    sel4 = 4'b0010; clr4 = 1'b0;
    #2;
    check_all("in_reset");
    step("in_reset_clk");
    rst_n = 1'b1;

    sel2 = 2'b01; step("sel01");
    cmp("sel01.out_const", 32'(out2), 32'h12345678);
    sel2 = 2'b10; step("sel10");
`ifdef ONEHOT_DATA_MUX_OUT_REG_EN
    cmp("sel10.reg_latency", 32'(out2), 32'hDEADBEEF);
`endif
    sel2 = 2'b00;
    repeat (3) step("sel00");
    cmp("sel00.sticky_const", 32'(sticky2), 32'h0);

    sel2 = 2'b11; step("sel11");
    step("sel11_held");
    cmp("sel11.out_const", 32'(out2), 32'hDEBDFEFF);
    cmp("sel11.sticky_const", 32'(sticky2), 32'h1);
    sel2 = 2'b01; step("sticky_hold");
    cmp("sticky_hold.const", 32'(sticky2), 32'h1);

    clr2 = 1'b1; step("clr_onehot");
    clr2 = 1'b0; step("after_clr");
    cmp("after_clr.const", 32'(sticky2), 32'h0);

    sel2 = 2'b11; step("reset_set");
    sel2 = 2'b11; clr2 = 1'b1; step("clr_vs_multi");
    clr2 = 1'b0; sel2 = 2'b01; step("clr_vs_multi_res");
    cmp("clr_vs_multi.const", 32'(sticky2), 32'h1);

    // Asynchronous reset between edges.
    rst_n = 1'b0;
    #1;
    cmp("async_rst.sticky2", 32'(sticky2), 32'h0);
    exp_sticky2 = 1'b0; exp_sticky4 = 1'b0; exp_q2 = '0; exp_q4 = '0;
    step("during_rst");
    rst_n = 1'b1;

    for (int i = 0; i < int'(N4); i++) begin
      sel4 = N4'(1) << i;
      step("walk4");
`ifndef ONEHOT_DATA_MUX_OUT_REG_EN
      cmp("walk4.const", 32'(out4), 32'(1) << i);
`endif
    end
    sel4 = 4'b1111; step("all_ones4");

    for (int n = 0; n < 300; n++) begin
      int mode;
      in2 = {$urandom(), $urandom()};
      in4 = $urandom();
      sel2 = N2'($urandom_range(0, 3));
      mode = int'($urandom_range(0, 3));
      if (mode == 0)      sel4 = N4'(1) << $urandom_range(0, N4 - 1);
      else if (mode == 1) sel4 = '0;
      else                sel4 = N4'($urandom());
      clr2 = ($urandom_range(0, 3) == 0);
      clr4 = ($urandom_range(0, 3) == 0);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
